recovery_ctrl: RTL and testbench
================================

# recovery_ctrl

Sequences branch-mispredict recovery around the rename/ROB datapath (rob, map_table, architecture_table, free_list). On a retiring mispredicted branch it flushes the speculative pipeline for one cycle. It then copies the architectural map into the speculative map table over several cycles, redirects fetch through a handshake, and returns to normal operation. Between recoveries it is the dispatch-width arbiter: the number of instructions allowed to dispatch each cycle is the minimum of fetch supply, free physical registers, free ROB entries and free RS entries.

## Interface
Parameters:
- N_WAY, 2, superscalar width
- ARCH_REGS, 32, architectural registers; a multiple of RPC
- CDB_BITS, 6, physical tag width
- XLEN, 32, PC width
- RPC, 4, map entries restored per cycle

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- branch_haz  in  1  mispredicted branch retiring this cycle
- br_target_pc  in  XLEN  correct target PC, valid with branch_haz
- arch_map  in  ARCH_REGS x CDB_BITS  committed map (arch_reg_next)
- fetch_num  in  clog2(N_WAY)+1  valid instructions offered by fetch
- free_num  in  clog2(N_WAY)+1  free-list availability
- empty_rob  in  clog2(N_WAY)+1  free ROB slots
- rs_free  in  clog2(N_WAY)+1  free RS slots
- fetch_ready  in  1  fetch accepts redirect
- dispatch_num  out  clog2(N_WAY)+1  dispatch grant count
- flush  out  1  clears RS, ROB speculative state and pipeline registers
- mt_wr_en  out  1  map-table restore write enable
- mt_wr_idx  out  clog2(ARCH_REGS)  first arch register of the group being written
- mt_wr_data  out  RPC x CDB_BITS  tags for arch regs mt_wr_idx .. mt_wr_idx+RPC-1
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  XLEN  redirect target
- busy  out  1  recovery in progress (state != IDLE)

## Operation
- The FSM has four states: IDLE, FLUSH, RESTORE, REDIRECT.
- IDLE:
  - dispatch_num = min(fetch_num, free_num, empty_rob, rs_free), saturated at N_WAY. All operands are unsigned.
  - When branch_haz=1: latch br_target_pc into pc_q, clear grp_cnt and go to FLUSH.
- FLUSH: lasts exactly 1 cycle; flush=1; then go to RESTORE.
- RESTORE:
  - mt_wr_en=1, mt_wr_idx = grp_cnt*RPC, mt_wr_data = arch_map[mt_wr_idx +: RPC].
  - grp_cnt increments each cycle. After group ARCH_REGS/RPC-1 is written, go to REDIRECT.
- REDIRECT:
  - redirect_valid=1, redirect_pc=pc_q.
  - When redirect_valid && fetch_ready, go to IDLE.
  - redirect_pc is held stable until the handshake completes.
- In every state other than IDLE, dispatch_num=0.
- branch_haz while busy=1 is ignored: that branch is younger and is flushed by the recovery in progress. pc_q is not overwritten.
- arch_map is sampled live each RESTORE cycle. Retirement is blocked while flushed, so arch_map is stable.
- Reset (low, at any time, including mid-RESTORE):
  - state=IDLE, grp_cnt=0, pc_q=0.
  - flush=0, mt_wr_en=0, mt_wr_idx=0, mt_wr_data=0, redirect_valid=0, redirect_pc=0, busy=0.
  - dispatch_num forced to 0 while reset is low.

## Timing
- branch_haz sampled at edge T: flush=1 during cycle T+1.
- RESTORE occupies cycles T+2 .. T+1+ARCH_REGS/RPC (T+2..T+9 at defaults).
- redirect_valid rises at T+2+ARCH_REGS/RPC.
- Minimum recovery is ARCH_REGS/RPC+2 cycles plus fetch_ready wait; 10 cycles at defaults with fetch_ready=1.
- The first dispatch_num>0 after recovery is possible in the cycle after the handshake cycle.
- All control outputs are Moore, decoded from registered state, counter and pc_q. dispatch_num is combinational from inputs and state.
- No output toggles mid-cycle except dispatch_num following its inputs.

## Structure
- Shared package (sys_defs): N_WAY, CDB_BITS, XLEN, ARCH_REGS, and the RECOVERY_STATE enum (IDLE, FLUSH, RESTORE, REDIRECT).
- One sub-module, disp_min: a combinational 4-input min-and-saturate used for dispatch_num.
- A single always_ff holds state, grp_cnt and pc_q, with async active-low reset.

## Test plan
- Reset mid-RESTORE: assert reset low during the 3rd RESTORE cycle -> next cycle all outputs 0, busy=0; after release, IDLE with dispatch_num=min(inputs).
- Dispatch arbitration in IDLE:
  - fetch_num=2, free_num=1, empty_rob=2, rs_free=2 -> dispatch_num=1.
  - All inputs 2 -> 2.
  - rs_free=0 -> 0.
- Full recovery: branch_haz with br_target_pc=0x0000_1040, fetch_ready=1, arch_map[i]=i+32 ->
  - flush=1 for exactly one cycle;
  - 8 writes with mt_wr_idx 0,4,…,28 and data {idx+32..idx+35};
  - redirect_pc=0x1040 for 1 cycle; busy for 10 cycles.
- Redirect backpressure: fetch_ready=0 for 5 cycles -> redirect_valid and redirect_pc=0x1040 held 6 cycles; IDLE the cycle after fetch_ready=1.
- Nested hazard: second branch_haz with pc 0x2000 during RESTORE -> ignored; redirect_pc stays 0x1040; one flush pulse only.
- Back-to-back: branch_haz asserted in the cycle IDLE is re-entered -> new recovery starts immediately; dispatch_num=0 throughout.

Source files
------------

// File: rtl/sys_defs.sv
// Shared recovery/dispatch configuration and the recovery FSM state encoding.
package sys_defs;

    localparam int unsigned N_WAY     = 2;
    localparam int unsigned CDB_BITS  = 6;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ARCH_REGS = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        RESTORE  = 2'd2,
        REDIRECT = 2'd3
    } recovery_state_e;

endpackage

// File: rtl/disp_min.sv
// Four-input unsigned minimum, saturated at the superscalar width.
module disp_min #(
    parameter int unsigned N_WAY = 2
) (
    input  logic [$clog2(N_WAY):0] i_a,
    input  logic [$clog2(N_WAY):0] i_b,
    input  logic [$clog2(N_WAY):0] i_c,
    input  logic [$clog2(N_WAY):0] i_d,
    output logic [$clog2(N_WAY):0] o_min
);

    localparam int unsigned CNT_W = $clog2(N_WAY) + 1;
    localparam logic [CNT_W-1:0] MAX_GRANT = CNT_W'(N_WAY);

    logic [CNT_W-1:0] w_ab;
    logic [CNT_W-1:0] w_cd;
    logic [CNT_W-1:0] w_abcd;

    always_comb begin
        w_ab   = (i_a < i_b) ? i_a : i_b;
        w_cd   = (i_c < i_d) ? i_c : i_d;
        w_abcd = (w_ab < w_cd) ? w_ab : w_cd;
        o_min  = (w_abcd > MAX_GRANT) ? MAX_GRANT : w_abcd;
    end

endmodule

// File: rtl/recovery_ctrl.sv
// Branch-mispredict recovery sequencer (flush, map restore, fetch redirect)
// and dispatch-width arbiter between recoveries.
module recovery_ctrl #(
    parameter int unsigned N_WAY     = sys_defs::N_WAY,
    parameter int unsigned ARCH_REGS = sys_defs::ARCH_REGS,
    parameter int unsigned CDB_BITS  = sys_defs::CDB_BITS,
    parameter int unsigned XLEN      = sys_defs::XLEN,
    parameter int unsigned RPC       = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  branch_haz,
    input  logic [XLEN-1:0]                       br_target_pc,
    input  logic [ARCH_REGS-1:0][CDB_BITS-1:0]    arch_map,
    input  logic [$clog2(N_WAY):0]                fetch_num,
    input  logic [$clog2(N_WAY):0]                free_num,
    input  logic [$clog2(N_WAY):0]                empty_rob,
    input  logic [$clog2(N_WAY):0]                rs_free,
    input  logic                                  fetch_ready,
    output logic [$clog2(N_WAY):0]                dispatch_num,
    output logic                                  flush,
    output logic                                  mt_wr_en,
    output logic [$clog2(ARCH_REGS)-1:0]          mt_wr_idx,
    output logic [RPC-1:0][CDB_BITS-1:0]          mt_wr_data,
    output logic                                  redirect_valid,
    output logic [XLEN-1:0]                       redirect_pc,
    output logic                                  busy
);

    import sys_defs::*;

    localparam int unsigned CNT_W = $clog2(N_WAY) + 1;
    localparam int unsigned IDX_W = $clog2(ARCH_REGS);
    localparam int unsigned N_GRP = ARCH_REGS / RPC;
    localparam int unsigned GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GRP - 1);

    recovery_state_e   r_state;
    recovery_state_e   w_state_nxt;
    logic [GRP_W-1:0]  r_grp_cnt;
    logic [GRP_W-1:0]  w_grp_cnt_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [CNT_W-1:0]  w_min;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_sel;

    disp_min #(
        .N_WAY (N_WAY)
    ) u_disp_min (
        .i_a   (fetch_num),
        .i_b   (free_num),
        .i_c   (empty_rob),
        .i_d   (rs_free),
        .o_min (w_min)
    );

    // A hazard seen while busy is younger than the one being recovered; drop it.
    always_comb begin
        w_state_nxt   = r_state;
        w_grp_cnt_nxt = r_grp_cnt;
        w_pc_nxt      = r_pc;
        case (r_state)
            IDLE: begin
                if (branch_haz) begin
                    w_state_nxt   = FLUSH;
                    w_pc_nxt      = br_target_pc;
                    w_grp_cnt_nxt = '0;
                end
            end
            FLUSH:    w_state_nxt = RESTORE;
            RESTORE: begin
                w_grp_cnt_nxt = r_grp_cnt + 1'b1;
                if (r_grp_cnt == LAST_GRP) begin
                    w_state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                if (fetch_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_grp_cnt <= '0;
            r_pc      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grp_cnt <= w_grp_cnt_nxt;
            r_pc      <= w_pc_nxt;
        end
    end

    always_comb begin
        busy           = (r_state != IDLE);
        flush          = (r_state == FLUSH);
        mt_wr_en       = (r_state == RESTORE);
        redirect_valid = (r_state == REDIRECT);
        redirect_pc    = redirect_valid ? r_pc : '0;
        dispatch_num   = (reset && (r_state == IDLE)) ? w_min : '0;
    end

    always_comb begin
        w_idx      = IDX_W'(32'(r_grp_cnt) * RPC);
        w_sel      = '0;
        mt_wr_idx  = '0;
        mt_wr_data = '0;
        if (r_state == RESTORE) begin
            mt_wr_idx = w_idx;
            for (int unsigned i = 0; i < RPC; i++) begin
                w_sel         = w_idx + IDX_W'(i);
                mt_wr_data[i] = arch_map[w_sel];
            end
        end
    end

endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed self-checking bench for recovery_ctrl at default parameters.
module tb_recovery_ctrl;

    logic              clock;
    logic              reset;
    logic              branch_haz;
    logic [31:0]       br_target_pc;
    logic [31:0][5:0]  arch_map;
    logic [1:0]        fetch_num;
    logic [1:0]        free_num;
    logic [1:0]        empty_rob;
    logic [1:0]        rs_free;
    logic              fetch_ready;
    logic [1:0]        dispatch_num;
    logic              flush;
    logic              mt_wr_en;
    logic [4:0]        mt_wr_idx;
    logic [3:0][5:0]   mt_wr_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    recovery_ctrl u_dut (
        .clock          (clock),
        .reset          (reset),
        .branch_haz     (branch_haz),
        .br_target_pc   (br_target_pc),
        .arch_map       (arch_map),
        .fetch_num      (fetch_num),
        .free_num       (free_num),
        .empty_rob      (empty_rob),
        .rs_free        (rs_free),
        .fetch_ready    (fetch_ready),
        .dispatch_num   (dispatch_num),
        .flush          (flush),
        .mt_wr_en       (mt_wr_en),
        .mt_wr_idx      (mt_wr_idx),
        .mt_wr_data     (mt_wr_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_inputs(input int f, input int fr, input int rob, input int rs);
        fetch_num = 2'(f);
        free_num  = 2'(fr);
        empty_rob = 2'(rob);
        rs_free   = 2'(rs);
    endtask

    // Present a hazard for one edge; returns sampling the FLUSH cycle.
    task automatic start_branch(input logic [31:0] pc);
        branch_haz   = 1'b1;
        br_target_pc = pc;
        tick();
        branch_haz   = 1'b0;
    endtask

    task automatic test_reset();
        set_inputs(2, 2, 2, 2);
        #1;
        n_checks++;
        if ({busy, flush, mt_wr_en, redirect_valid} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got busy/flush/wr/redir=%b required 0000",
                     {busy, flush, mt_wr_en, redirect_valid});
        end
        n_checks++;
        if (dispatch_num !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_dispatch: got %0d required 0", dispatch_num);
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (dispatch_num !== 2'd2 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got disp=%0d busy=%b required 2/0", dispatch_num, busy);
        end
    endtask

    task automatic test_dispatch();
        int tv [6][5];
        tv = '{'{2, 1, 2, 2, 1}, '{2, 2, 2, 2, 2}, '{2, 2, 2, 0, 0},
               '{3, 3, 3, 3, 2}, '{1, 3, 2, 3, 1}, '{3, 2, 3, 3, 2}};
        for (int i = 0; i < 6; i++) begin
            set_inputs(tv[i][0], tv[i][1], tv[i][2], tv[i][3]);
            #1;
            n_checks++;
            if (dispatch_num !== 2'(tv[i][4])) begin
                n_errors++;
                $display("FAIL dispatch_vec%0d: got %0d required %0d", i, dispatch_num, tv[i][4]);
            end
        end
        set_inputs(2, 2, 2, 2);
        tick();
    endtask

    task automatic test_full_recovery();
        int n_flush = 0;
        int n_busy  = 0;
        logic [3:0][5:0] exp_d;
        set_inputs(2, 2, 2, 2);
        fetch_ready = 1'b1;
        start_branch(32'h0000_1040);
        for (int c = 1; c <= 11; c++) begin
            n_flush += int'(flush);
            n_busy  += int'(busy);
            n_checks++;
            if (flush !== (c == 1)) begin
                n_errors++;
                $display("FAIL full_flush_c%0d: got %b required %b", c, flush, (c == 1));
            end
            n_checks++;
            if (dispatch_num !== ((c == 11) ? 2'd2 : 2'd0)) begin
                n_errors++;
                $display("FAIL full_dispatch_c%0d: got %0d", c, dispatch_num);
            end
            if (c >= 2 && c <= 9) begin
                for (int j = 0; j < 4; j++) exp_d[j] = 6'((c - 2) * 4 + j + 32);
                n_checks++;
                if (mt_wr_en !== 1'b1 || mt_wr_idx !== 5'((c - 2) * 4) || mt_wr_data !== exp_d)
                begin
                    n_errors++;
                    $display("FAIL full_restore_c%0d: got en=%b idx=%0d data=%h required 1/%0d/%h",
                             c, mt_wr_en, mt_wr_idx, mt_wr_data, (c - 2) * 4, exp_d);
                end
            end else begin
                n_checks++;
                if (mt_wr_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL full_wr_idle_c%0d: got %b required 0", c, mt_wr_en);
                end
            end
            n_checks++;
            if (redirect_valid !== (c == 10) || (c == 10 && redirect_pc !== 32'h1040)) begin
                n_errors++;
                $display("FAIL full_redirect_c%0d: got v=%b pc=%h", c, redirect_valid, redirect_pc);
            end
            if (c < 11) tick();
        end
        n_checks++;
        if (n_flush != 1 || n_busy != 10) begin
            n_errors++;
            $display("FAIL full_counts: got flush=%0d busy=%0d required 1/10", n_flush, n_busy);
        end
    endtask

    task automatic test_backpressure();
        int n_held = 0;
        fetch_ready = 1'b0;
        start_branch(32'h0000_1040);
        for (int c = 1; c <= 9; c++) tick();
        for (int k = 0; k < 6; k++) begin
            if (redirect_valid === 1'b1 && redirect_pc === 32'h1040 && busy === 1'b1) n_held++;
            if (k == 5) fetch_ready = 1'b1;
            tick();
        end
        n_checks++;
        if (n_held != 6) begin
            n_errors++;
            $display("FAIL bp_hold: got %0d held cycles required 6", n_held);
        end
        n_checks++;
        if (busy !== 1'b0 || redirect_valid !== 1'b0 || dispatch_num !== 2'd2) begin
            n_errors++;
            $display("FAIL bp_release: got busy=%b v=%b disp=%0d required 0/0/2",
                     busy, redirect_valid, dispatch_num);
        end
    endtask

    task automatic test_nested();
        int n_flush = 0;
        fetch_ready = 1'b1;
        start_branch(32'h0000_1040);
        for (int c = 1; c <= 11; c++) begin
            n_flush += int'(flush);
            if (redirect_valid) begin
                n_checks++;
                if (redirect_pc !== 32'h1040) begin
                    n_errors++;
                    $display("FAIL nested_pc: got %h required 00001040", redirect_pc);
                end
            end
            if (c == 9) begin
                n_checks++;
                if (mt_wr_idx !== 5'd28) begin
                    n_errors++;
                    $display("FAIL nested_last_idx: got %0d required 28", mt_wr_idx);
                end
            end
            branch_haz   = (c == 3 || c == 4);
            br_target_pc = (c == 3 || c == 4) ? 32'h2000 : 32'h0;
            if (c < 11) tick();
        end
        branch_haz = 1'b0;
        n_checks++;
        if (n_flush != 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL nested_end: got flush=%0d busy=%b required 1/0", n_flush, busy);
        end
    endtask

    task automatic test_reset_mid_restore();
        set_inputs(2, 2, 2, 2);
        fetch_ready = 1'b1;
        start_branch(32'h0000_1040);
        tick();
        tick();
        tick();
        n_checks++;
        if (mt_wr_en !== 1'b1 || mt_wr_idx !== 5'd8) begin
            n_errors++;
            $display("FAIL rst_mid_pre: got en=%b idx=%0d required 1/8", mt_wr_en, mt_wr_idx);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, flush, mt_wr_en, redirect_valid} !== 4'b0000 || mt_wr_idx !== 5'd0 ||
            mt_wr_data !== '0 || redirect_pc !== 32'd0 || dispatch_num !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: got ctl=%b idx=%0d data=%h pc=%h disp=%0d required 0",
                     {busy, flush, mt_wr_en, redirect_valid}, mt_wr_idx, mt_wr_data,
                     redirect_pc, dispatch_num);
        end
        tick();
        reset = 1'b1;
        set_inputs(2, 1, 2, 2);
        #1;
        n_checks++;
        if (busy !== 1'b0 || dispatch_num !== 2'd1) begin
            n_errors++;
            $display("FAIL rst_mid_release: got busy=%b disp=%0d required 0/1", busy, dispatch_num);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || mt_wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_idle: got busy=%b en=%b required 0/0", busy, mt_wr_en);
        end
    endtask

    task automatic test_back_to_back();
        int n_bad = 0;
        set_inputs(2, 2, 2, 2);
        fetch_ready = 1'b1;
        start_branch(32'h0000_1040);
        for (int c = 1; c < 10; c++) begin
            if (dispatch_num !== 2'd0 || busy !== 1'b1) n_bad++;
            tick();
        end
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1040) begin
            n_errors++;
            $display("FAIL b2b_first_redirect: got v=%b pc=%h required 1/00001040",
                     redirect_valid, redirect_pc);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle: got busy=%b required 0", busy);
        end
        start_branch(32'h0000_3000);
        n_checks++;
        if (flush !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_flush: got %b required 1", flush);
        end
        for (int c = 1; c <= 10; c++) begin
            if (dispatch_num !== 2'd0 || busy !== 1'b1) n_bad++;
            if (c == 2) begin
                n_checks++;
                if (mt_wr_idx !== 5'd0 || mt_wr_en !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_restart_idx: got en=%b idx=%0d required 1/0",
                             mt_wr_en, mt_wr_idx);
                end
            end
            if (c == 10) begin
                n_checks++;
                if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000) begin
                    n_errors++;
                    $display("FAIL b2b_second_redirect: got v=%b pc=%h required 1/00003000",
                             redirect_valid, redirect_pc);
                end
            end
            tick();
        end
        n_checks++;
        if (n_bad != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_busy_dispatch: got %0d bad cycles busy=%b required 0/0", n_bad, busy);
        end
    endtask

    initial begin
        reset        = 1'b0;
        branch_haz   = 1'b0;
        br_target_pc = '0;
        fetch_ready  = 1'b0;
        for (int i = 0; i < 32; i++) arch_map[i] = 6'(i + 32);
        set_inputs(0, 0, 0, 0);
        test_reset();
        test_dispatch();
        test_full_recovery();
        test_backpressure();
        test_nested();
        test_reset_mid_restore();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
